// File: rtl/ibex_cheri_mem_resp_tracker_pkg.sv
// ibex_cheri_mem_resp_tracker_pkg: CHERI exception indices, cause codes and priority encoder.
// IBEX_CHERI_RESP_ADDR_EN adds the per-entry address to resp_entry storage.
package ibex_cheri_mem_resp_tracker_pkg;

  localparam int unsigned CheriExcWidth = 6;

  localparam int unsigned LENGTH_VIOLATION         = 0;
  localparam int unsigned TAG_VIOLATION            = 1;
  localparam int unsigned SEAL_VIOLATION           = 2;
  localparam int unsigned PERMIT_EXECUTE_VIOLATION = 3;
  localparam int unsigned PERMIT_LOAD_VIOLATION    = 4;
  localparam int unsigned PERMIT_STORE_VIOLATION   = 5;

  typedef enum logic [4:0] {
    CheriCauseNone      = 5'h00,
    CheriCauseLength    = 5'h01,
    CheriCauseTag       = 5'h02,
    CheriCauseSeal      = 5'h03,
    CheriCausePermExec  = 5'h11,
    CheriCausePermLoad  = 5'h12,
    CheriCausePermStore = 5'h13
  } cheri_cause_e;

  // Load/store permission bits only matter on the data port, execute only on the fetch port.
  function automatic cheri_cause_e cheri_exc_prio_encode(input logic [CheriExcWidth-1:0] exc,
                                                         input logic we,
                                                         input logic data_mem);
    return exc[TAG_VIOLATION]                               ? CheriCauseTag       :
           exc[SEAL_VIOLATION]                              ? CheriCauseSeal      :
           (~data_mem & exc[PERMIT_EXECUTE_VIOLATION])      ? CheriCausePermExec  :
           (data_mem & ~we & exc[PERMIT_LOAD_VIOLATION])    ? CheriCausePermLoad  :
           (data_mem & we & exc[PERMIT_STORE_VIOLATION])    ? CheriCausePermStore :
           exc[LENGTH_VIOLATION]                            ? CheriCauseLength    :
                                                              CheriCauseNone;
  endfunction

endpackage

// File: rtl/ibex_cheri_mem_resp_tracker_fifo.sv
// ibex_cheri_resp_fifo: in-order FIFO with a second, index-addressed write port
// for a late-arriving field that carries its own valid bit per entry.
module ibex_cheri_resp_fifo #(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 1,
  parameter int unsigned LateWidth = 1,
  localparam int unsigned IdxW     = Depth > 1 ? $clog2(Depth) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  output logic [IdxW-1:0]      push_idx_o,
  input  logic                 pop_i,
  input  logic                 late_we_i,
  input  logic [IdxW-1:0]      late_idx_i,
  input  logic [LateWidth-1:0] late_data_i,
  output logic [DataWidth-1:0] head_data_o,
  output logic [LateWidth-1:0] head_late_o,
  output logic                 head_late_valid_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] data_q [Depth];
  logic [LateWidth-1:0] late_q [Depth];
  logic [Depth-1:0]     late_valid_q;
  logic [IdxW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 push_en, pop_en;

  assign full_o            = cnt_q == CntW'(Depth);
  assign empty_o           = cnt_q == '0;
  assign push_en           = push_i & ~full_o;
  assign pop_en            = pop_i & ~empty_o;
  assign push_idx_o        = wptr_q;
  assign head_data_o       = data_q[rptr_q];
  assign head_late_o       = late_q[rptr_q];
  assign head_late_valid_o = late_valid_q[rptr_q];

  always_comb begin
    wptr_d = push_en ? (wptr_q == IdxW'(Depth - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = pop_en ? (rptr_q == IdxW'(Depth - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d  = cnt_q + CntW'(push_en) - CntW'(pop_en);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      late_valid_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (late_we_i) late_valid_q[late_idx_i] <= 1'b1;
      if (push_en) late_valid_q[wptr_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (late_we_i) late_q[late_idx_i] <= late_data_i;
    if (push_en) data_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ibex_cheri_mem_resp_tracker.sv
// ibex_cheri_mem_resp_tracker: pairs bus responses with their CHERI check results.
// IBEX_CHERI_RESP_ADDR_EN enables per-entry address storage for resp_addr_o.
module ibex_cheri_mem_resp_tracker
  import ibex_cheri_mem_resp_tracker_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter bit          DataMem        = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     gnt_i,
  input  logic [31:0]              addr_i,
  input  logic                     we_i,
  input  logic [CheriExcWidth-1:0] cheri_mem_exc_i,
  input  logic                     instr_upper_exc_i,
  input  logic                     rvalid_i,
  input  logic                     err_i,
  output logic                     full_o,
  output logic                     busy_o,
  output logic                     resp_valid_o,
  output logic                     resp_cheri_exc_o,
  output logic [4:0]               resp_cause_o,
  output logic                     resp_upper_only_o,
  output logic                     resp_bus_err_o,
  output logic [31:0]              resp_addr_o,
  output logic                     resp_squash_o
);

  localparam int unsigned IdxW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
`ifdef IBEX_CHERI_RESP_ADDR_EN
  localparam int unsigned DataW = 33;
`else
  localparam int unsigned DataW = 1;
`endif

  logic                   push, pop, empty, head_late_valid;
  logic                   cap_pending_q, cap_pending_d;
  logic [IdxW-1:0]        push_idx, cap_idx_q, cap_idx_d;
  logic [DataW-1:0]       push_data, head_data;
  logic [CheriExcWidth:0] head_late, exc_src;
  cheri_cause_e           cause, cause_d, resp_cause_q;
  logic                   upper_only, cheri_exc;
  logic [31:0]            fault_addr, resp_addr_q;
  logic                   resp_valid_q, resp_exc_q, resp_upper_q, resp_err_q, resp_squash_q;

  assign push   = req_i & gnt_i & ~full_o;
  assign pop    = rvalid_i & ~empty;
  assign busy_o = ~empty;

  ibex_cheri_resp_fifo #(
    .Depth    (MaxOutstanding),
    .DataWidth(DataW),
    .LateWidth(CheriExcWidth + 1)
  ) u_fifo (
    .clk_i,
    .rst_ni,
    .push_i           (push),
    .push_data_i      (push_data),
    .push_idx_o       (push_idx),
    .pop_i            (pop),
    .late_we_i        (cap_pending_q),
    .late_idx_i       (cap_idx_q),
    .late_data_i      ({instr_upper_exc_i, cheri_mem_exc_i}),
    .head_data_o      (head_data),
    .head_late_o      (head_late),
    .head_late_valid_o(head_late_valid),
    .full_o           (full_o),
    .empty_o          (empty)
  );

  // A head without captured exceptions was granted last cycle, so its check result is still on the inputs.
  always_comb begin
    exc_src       = head_late_valid ? head_late : {instr_upper_exc_i, cheri_mem_exc_i};
    cause         = cheri_exc_prio_encode(exc_src[CheriExcWidth-1:0], head_data[0], DataMem);
    upper_only    = ~DataMem & exc_src[CheriExcWidth] & (cause == CheriCauseNone);
    cheri_exc     = (cause != CheriCauseNone) | upper_only;
    cause_d       = upper_only ? CheriCauseLength : cause;
    cap_pending_d = push;
    cap_idx_d     = push ? push_idx : cap_idx_q;
  end

`ifdef IBEX_CHERI_RESP_ADDR_EN
  assign push_data  = {addr_i, we_i};
  assign fault_addr = cheri_exc ? head_data[32:1] | {30'b0, upper_only, 1'b0} : '0;
`else
  logic unused_addr;
  assign unused_addr = ^addr_i;
  assign push_data   = we_i;
  assign fault_addr  = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_pending_q <= 1'b0;
      cap_idx_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_exc_q    <= 1'b0;
      resp_cause_q  <= CheriCauseNone;
      resp_upper_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_addr_q   <= '0;
      resp_squash_q <= 1'b0;
    end else begin
      cap_pending_q <= cap_pending_d;
      cap_idx_q     <= cap_idx_d;
      resp_valid_q  <= pop;
      resp_exc_q    <= pop & cheri_exc;
      resp_cause_q  <= pop ? cause_d : CheriCauseNone;
      resp_upper_q  <= pop & upper_only;
      resp_err_q    <= pop & err_i;
      resp_addr_q   <= pop ? fault_addr : '0;
      resp_squash_q <= pop & ((cheri_exc & ~upper_only) | err_i);
    end
  end

  assign resp_valid_o      = resp_valid_q;
  assign resp_cheri_exc_o  = resp_exc_q;
  assign resp_cause_o      = resp_cause_q;
  assign resp_upper_only_o = resp_upper_q;
  assign resp_bus_err_o    = resp_err_q;
  assign resp_addr_o       = resp_addr_q;
  assign resp_squash_o     = resp_squash_q;

  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req_i & gnt_i & full_o));
  a_no_rvalid_when_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rvalid_i & empty & ~(req_i & gnt_i)));

endmodule

// File: tb/tb_ibex_cheri_mem_resp_tracker.sv
// tb_ibex_cheri_mem_resp_tracker: scoreboard bench driving a data-port and an instruction-port tracker.
module tb_ibex_cheri_mem_resp_tracker;
  import ibex_cheri_mem_resp_tracker_pkg::*;

  logic clk = 1'b0, rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic d_req, d_gnt, d_we, d_rvalid, d_err, d_upper;
  logic [31:0] d_addr;
  logic [CheriExcWidth-1:0] d_exc;
  logic d_full, d_busy, d_rv, d_cexc, d_uo, d_berr, d_sq;
  logic [4:0] d_cause;
  logic [31:0] d_raddr;

  logic i_req, i_gnt, i_we, i_rvalid, i_err, i_upper;
  logic [31:0] i_addr;
  logic [CheriExcWidth-1:0] i_exc;
  logic i_full, i_busy, i_rv, i_cexc, i_uo, i_berr, i_sq;
  logic [4:0] i_cause;
  logic [31:0] i_raddr;

  ibex_cheri_mem_resp_tracker #(.MaxOutstanding(2), .DataMem(1'b1)) u_dmem (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(d_req), .gnt_i(d_gnt), .addr_i(d_addr), .we_i(d_we),
    .cheri_mem_exc_i(d_exc), .instr_upper_exc_i(d_upper), .rvalid_i(d_rvalid), .err_i(d_err),
    .full_o(d_full), .busy_o(d_busy), .resp_valid_o(d_rv), .resp_cheri_exc_o(d_cexc),
    .resp_cause_o(d_cause), .resp_upper_only_o(d_uo), .resp_bus_err_o(d_berr),
    .resp_addr_o(d_raddr), .resp_squash_o(d_sq));

  ibex_cheri_mem_resp_tracker #(.MaxOutstanding(2), .DataMem(1'b0)) u_imem (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(i_req), .gnt_i(i_gnt), .addr_i(i_addr), .we_i(i_we),
    .cheri_mem_exc_i(i_exc), .instr_upper_exc_i(i_upper), .rvalid_i(i_rvalid), .err_i(i_err),
    .full_o(i_full), .busy_o(i_busy), .resp_valid_o(i_rv), .resp_cheri_exc_o(i_cexc),
    .resp_cause_o(i_cause), .resp_upper_only_o(i_uo), .resp_bus_err_o(i_berr),
    .resp_addr_o(i_raddr), .resp_squash_o(i_sq));

  // {cheri_exc, cause, upper_only, bus_err, addr, squash}
  typedef logic [40:0] resp_t;
  resp_t dq[$], iq[$];
  int tests = 0, fails = 0;

  function automatic logic [CheriExcWidth-1:0] eb(input int unsigned i);
    return CheriExcWidth'(1) << i;
  endfunction

  function automatic resp_t mk(input logic exc, input logic [4:0] cause, input logic uo,
                               input logic berr, input logic [31:0] a, input logic sq);
`ifdef IBEX_CHERI_RESP_ADDR_EN
    return {exc, cause, uo, berr, a, sq};
`else
    return {exc, cause, uo, berr, 32'h0, sq};
`endif
  endfunction

  task automatic chk(input string n, input logic [40:0] act, input logic [40:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (d_rv) begin
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL d_unexpected_resp: got resp_valid_o=1 expected no response");
      end else chk("d_resp", {d_cexc, d_cause, d_uo, d_berr, d_raddr, d_sq}, dq.pop_front());
    end
    if (i_rv) begin
      if (iq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL i_unexpected_resp: got resp_valid_o=1 expected no response");
      end else chk("i_resp", {i_cexc, i_cause, i_uo, i_berr, i_raddr, i_sq}, iq.pop_front());
    end
  end

  task automatic d_hs(input logic [31:0] a, input logic we);
    d_req = 1'b1; d_gnt = 1'b1; d_addr = a; d_we = we;
    step();
    d_req = 1'b0; d_gnt = 1'b0;
  endtask

  task automatic i_hs(input logic [31:0] a);
    i_req = 1'b1; i_gnt = 1'b1; i_addr = a;
    step();
    i_req = 1'b0; i_gnt = 1'b0;
  endtask

  task automatic d_clean_load(input logic [31:0] a);
    d_hs(a, 1'b0);
    d_exc = '0;
    chk("busy_after_grant", d_busy, 1);
    step();
    step();
    dq.push_back(mk(1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b0));
    d_rvalid = 1'b1;
    step();
    d_rvalid = 1'b0;
    step();
  endtask

  initial begin
    {d_req, d_gnt, d_we, d_rvalid, d_err, d_upper} = '0;
    {i_req, i_gnt, i_we, i_rvalid, i_err, i_upper} = '0;
    d_addr = '0; d_exc = '0; i_addr = '0; i_exc = '0;
    step();
    step();
    chk("rst_d_flags", {d_full, d_busy, d_rv}, 0);
    chk("rst_d_resp", {d_cexc, d_cause, d_uo, d_berr, d_raddr, d_sq}, 0);
    chk("rst_i_flags", {i_full, i_busy, i_rv}, 0);
    rst_ni = 1'b1;
    step();

    d_clean_load(32'h1000);

    // Response in the cycle right after the grant takes the live exception vector
    d_hs(32'h2004, 1'b0);
    d_exc = eb(TAG_VIOLATION) | eb(LENGTH_VIOLATION);
    d_rvalid = 1'b1;
    dq.push_back(mk(1'b1, 5'h02, 1'b0, 1'b0, 32'h2004, 1'b1));
    step();
    d_exc = '0; d_rvalid = 1'b0;
    step();

    d_hs(32'h500, 1'b1);
    d_exc = eb(PERMIT_STORE_VIOLATION) | eb(PERMIT_LOAD_VIOLATION);
    step();
    d_exc = '0;
    dq.push_back(mk(1'b1, 5'h13, 1'b0, 1'b0, 32'h500, 1'b1));
    d_rvalid = 1'b1;
    step();
    d_rvalid = 1'b0;

    d_hs(32'h508, 1'b0);
    d_exc = eb(PERMIT_STORE_VIOLATION) | eb(PERMIT_LOAD_VIOLATION);
    step();
    d_exc = '0;
    dq.push_back(mk(1'b1, 5'h12, 1'b0, 1'b0, 32'h508, 1'b1));
    d_rvalid = 1'b1;
    step();
    d_rvalid = 1'b0;

    d_hs(32'h600, 1'b0);
    step();
    dq.push_back(mk(1'b0, 5'h00, 1'b0, 1'b1, 32'h0, 1'b1));
    d_rvalid = 1'b1; d_err = 1'b1;
    step();
    d_rvalid = 1'b0; d_err = 1'b0;
    step();

    // Two back-to-back grants fill the two-entry FIFO
    d_req = 1'b1; d_gnt = 1'b1; d_addr = 32'h100; d_we = 1'b0;
    step();
    d_addr = 32'h104; d_exc = '0;
    chk("full_after_one", d_full, 0);
    step();
    d_req = 1'b0; d_gnt = 1'b0; d_exc = eb(LENGTH_VIOLATION);
    chk("full_after_two", d_full, 1);
    step();
    d_exc = '0;
    dq.push_back(mk(1'b0, 5'h00, 1'b0, 1'b0, 32'h0, 1'b0));
    dq.push_back(mk(1'b1, 5'h01, 1'b0, 1'b0, 32'h104, 1'b1));
    d_rvalid = 1'b1;
    step();
    chk("full_drop_after_rvalid", d_full, 0);
    step();
    d_rvalid = 1'b0;
    chk("idle_after_drain", d_busy, 0);
    step();

    i_hs(32'h3000);
    i_upper = 1'b1;
    step();
    i_upper = 1'b0;
    iq.push_back(mk(1'b1, 5'h01, 1'b1, 1'b0, 32'h3002, 1'b0));
    i_rvalid = 1'b1;
    step();
    i_rvalid = 1'b0;

    // Execute fault outranks an upper-half fault, so no upper_only and no +2
    i_hs(32'h4000);
    i_exc = eb(PERMIT_EXECUTE_VIOLATION) | eb(PERMIT_LOAD_VIOLATION);
    i_upper = 1'b1;
    step();
    i_exc = '0; i_upper = 1'b0;
    iq.push_back(mk(1'b1, 5'h11, 1'b0, 1'b0, 32'h4000, 1'b1));
    i_rvalid = 1'b1;
    step();
    i_rvalid = 1'b0;
    step();

    d_req = 1'b1; d_gnt = 1'b1; d_addr = 32'h700; d_we = 1'b0;
    step();
    d_addr = 32'h704;
    step();
    d_req = 1'b0; d_gnt = 1'b0; d_exc = eb(TAG_VIOLATION);
    chk("full_before_reset", d_full, 1);
    rst_ni = 1'b0;
    #1;
    chk("reset_busy", d_busy, 0);
    chk("reset_full", d_full, 0);
    step();
    d_exc = '0;
    step();
    rst_ni = 1'b1;
    step();
    d_clean_load(32'h1000);

    for (int k = 0; k < 20 && (dq.size() != 0 || iq.size() != 0); k++) step();
    chk("scoreboard_drained", dq.size() + iq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
